// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: SYNC, LSB-first bit-stuffed payload, NRZI line coding and EOP.
// The line registers load at the edge that opens a cell, so the line and tx_active show that cell.
module usb_tx_packetizer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SYNC_LEN  = 8,
    parameter int unsigned STUFF_RUN = 6,
    parameter int unsigned EOP_SE0   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              DP_line,
    output logic              DM_line,
    output logic              tx_active,
    output logic              tx_err
);

    localparam int unsigned MAX_A   = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
    localparam int unsigned MAX_LEN = (MAX_A > EOP_SE0) ? MAX_A : EOP_SE0;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W   = $clog2(DATA_W);
    localparam int unsigned RUN_W   = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  ones_q, ones_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              level_q, level_d;
    logic              dp_q, dp_d;
    logic              dm_q, dm_d;
    logic              field_end, stuff_due, stuff_next;
    logic              ready_int, err_int, raw_n, se0_n;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        last_d     = last_q;
        stuff_next = 1'b0;
        ready_int  = 1'b0;
        err_int    = 1'b0;
        field_end  = (state_q == StSync && cnt_q == CNT_W'(SYNC_LEN - 1)) ||
                     (state_q == StData && cnt_q == CNT_W'(DATA_W - 1));
        stuff_due  = (ones_q == RUN_W'(STUFF_RUN));

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d = StSync;
                    cnt_d   = '0;
                end
            end
            StSync, StData: begin
                // A stuff cell keeps cnt on the bit it follows, so a trailing stuff cell
                // is itself the field end and carries the deferred handshake.
                if (stuff_due) begin
                    stuff_next = 1'b1;
                end else if (!field_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (state_q == StData && last_q) begin
                    state_d = StEopSe0;
                    cnt_d   = '0;
                end else begin
                    ready_int = 1'b1;
                    cnt_d     = '0;
                    if (tx_valid) begin
                        state_d = StData;
                        word_d  = tx_data;
                        last_d  = tx_last;
                    end else begin
                        err_int = 1'b1;
                        state_d = StEopSe0;
                    end
                end
            end
            StEopSe0: begin
                if (cnt_q == CNT_W'(EOP_SE0 - 1)) begin
                    state_d = StEopJ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEopJ:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Raw bit, NRZI level and ones run of the cell that opens at the next edge.
    always_comb begin
        raw_n   = 1'b1;
        se0_n   = 1'b0;
        level_d = 1'b1;
        ones_d  = '0;
        unique case (state_d)
            StSync:   raw_n = stuff_next ? 1'b0 : (cnt_d == CNT_W'(SYNC_LEN - 1));
            StData:   raw_n = stuff_next ? 1'b0 : word_d[cnt_d[IDX_W-1:0]];
            StEopSe0: se0_n = 1'b1;
            default:  raw_n = 1'b1;
        endcase
        if (state_d inside {StSync, StData}) begin
            level_d = raw_n ? level_q : ~level_q;
            ones_d  = raw_n ? ones_q + 1'b1 : '0;
        end
        dp_d = ~se0_n & level_d;
        dm_d = ~se0_n & ~level_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ones_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            level_q <= 1'b1;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            word_q  <= word_d;
            last_q  <= last_d;
            level_q <= level_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
        end
    end

    assign tx_ready  = ready_int & reset;
    assign tx_err    = err_int & reset;
    assign tx_active = (state_q != StIdle);
    assign DP_line   = dp_q;
    assign DM_line   = dm_q;

endmodule
